ball_engine: RTL
================

# ball_engine

Parametrised second-generation Pong ball engine: frame-tick-stepped motion, explicit serve/play/score state machine, hit-count speed ramp with saturation, and clamped wall/paddle reflection. Sits between the keyboard decoder, the two paddle blocks, and the VGA renderer/scoreboard. It replaces the free-running per-clock ball mover with a frame-paced engine.

## Interface
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height
- BALL_W / BALL_H, 20 / 20, ball size
- P1_X / P2_X, 10 / 615, paddle left-edge X positions
- PADDLE_W / PADDLE_H, 15 / 100, paddle size
- START_SPEED, 5, pixels per tick at serve
- MAX_SPEED, 15, speed saturation value
- SPEED_STEP, 5, speed increment per ramp step
- HITS_PER_STEP, 5, paddle hits per ramp step
- SERVE_DELAY, 60, frame ticks held at centre before launch
- START_KEY / RESTART_KEY, 103 / 98, key codes
- i_CLK  in  1  system clock; single clock domain
- i_RST_N  in  1  synchronous active-low reset
- i_frame_tick  in  1  one-cycle pulse per video frame
- i_key_valid  in  1  i_key_byte qualifier
- i_key_byte  in  8  key code
- i_p1_y / i_p2_y  in  10  paddle top Y
- o_ball_x / o_ball_y  out  10  ball top-left, registered
- o_p1_scored / o_p2_scored  out  1  one-cycle score pulses
- o_state  out  2  FSM state
- o_speed  out  5  current speed

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, SCORED=3.
- IDLE: ball at centre, (SCREEN_W-BALL_W)/2, (SCREEN_H-BALL_H)/2. i_key_valid with START_KEY goes to SERVE.
- SERVE: ball held at centre. Count i_frame_tick up to SERVE_DELAY, then go to PLAY. Launch direction:
  - dx toward the player who conceded the last point; the first serve goes right.
  - dy alternates each serve; the first serve goes down.
- PLAY: each tick, compute next = pos ± speed in 11-bit signed arithmetic. Checks are evaluated on next, in priority order:
  1. Paddle. Moving left: ball x ≥ P1_X+PADDLE_W, next_x < P1_X+PADDLE_W, and Y overlap (ball_y+BALL_H > p1_y && ball_y < p1_y+PADDLE_H). Then x is clamped to P1_X+PADDLE_W, dx flips, and hits increments. P2 is mirrored, using face P2_X-BALL_W.
  2. Score. next_x < 0: o_p2_scored. next_x+BALL_W > SCREEN_W: o_p1_scored. Either goes to SCORED.
  3. Y walls, independent of X. next_y ≤ 0: y=0, dy becomes down. next_y+BALL_H ≥ SCREEN_H: y=SCREEN_H-BALL_H, dy becomes up.
- SCORED: lasts one cycle. Pulse the score output, reset speed to START_SPEED and hits to 0, then go to SERVE.
- Speed ramp: when the hit count reaches a multiple of HITS_PER_STEP, speed += SPEED_STEP, saturating at MAX_SPEED. Hits saturate at 31.
- RESTART_KEY in any state goes to IDLE; ball centred, speed and hits cleared. Keys are ignored when i_key_valid=0.

## Timing
- Reset values: state IDLE, ball centred, scored outputs 0, o_speed=START_SPEED, hits 0, serve counter 0.
- Position updates appear on outputs the cycle after i_frame_tick. No motion occurs without a tick.
- A speed change takes effect on the tick after the hit.
- RESTART and a tick in the same cycle: RESTART wins.
- Paddle and Y-wall reflection in the same tick: both apply.
- Reset asserted mid-PLAY: IDLE next cycle and all state cleared.
- Score pulses are exactly one cycle wide and never both asserted together.

## Configuration
- BALL_ENGINE_SPIN_EN defined: paddle hits set |dy| by hit zone, using ball centre against paddle thirds.
  - Outer thirds: |dy| = speed.
  - Middle third: |dy| = max(speed>>1, 1).
  - dy sign is unchanged.
- Undefined: |dy| is always speed, giving pure 45° motion.

## Structure
- pong_pkg: state enum, SCREEN_W/SCREEN_H defaults, key-code constants. Shared with the paddle and scoreboard blocks.
- Sub-module ball_speed_ctrl: hit counter, ramp, saturation and clear. Inputs are hit pulse and clear; output is speed.

## Test plan
- Reset, START, 60 ticks: state goes SERVE then PLAY. x goes 310→315→320 on successive ticks, y goes 230→235.
- Ball at y=5 moving up, speed 5: clamps to y=0 and dy becomes down. Next tick y=5.
- p1_y=200, ball (30,250) moving left: clamps x=25, dx becomes right, hits=1. Same setup with p1_y=0: no bounce, o_p2_scored pulses for 1 cycle, state goes to SERVE.
- 5 paddle hits: o_speed 5→10. 10 hits: 15. 15 hits: stays 15. After a score, o_speed returns to 5.
- RESTART during PLAY coincident with a tick: IDLE and ball centred next cycle. Reset mid-SERVE: IDLE and counter 0.
- With BALL_ENGINE_SPIN_EN, a middle-third hit at speed 10 gives |dy|=5. Without it, |dy|=10.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong FSM encoding, playfield defaults and key codes
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        PLAY   = 2'd2,
        SCORED = 2'd3
    } state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    localparam logic [7:0] KEY_START   = 8'd103;
    localparam logic [7:0] KEY_RESTART = 8'd98;

endpackage

// File: rtl/ball_speed_ctrl.sv
// rtl/ball_speed_ctrl.sv - paddle hit counter driving a saturating speed ramp
module ball_speed_ctrl #(
    parameter int START_SPEED   = 5,
    parameter int MAX_SPEED     = 15,
    parameter int SPEED_STEP    = 5,
    parameter int HITS_PER_STEP = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       hit,
    input  logic       clear,
    output logic [4:0] speed
);

    logic [4:0] hits;
    logic [4:0] hits_inc;
    logic [5:0] speed_sum;

    assign hits_inc  = hits + 5'd1;
    assign speed_sum = {1'b0, speed} + 6'(SPEED_STEP);

    // Clear outranks a coincident hit so a score or restart always restarts the ramp.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            hits  <= '0;
            speed <= 5'(START_SPEED);
        end else if (hit && hits != 5'd31) begin
            hits <= hits_inc;
            if ((int'(hits_inc) % HITS_PER_STEP) == 0)
                speed <= (speed_sum > 6'(MAX_SPEED)) ? 5'(MAX_SPEED) : speed_sum[4:0];
        end
    end

endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - frame-paced Pong ball engine; BALL_ENGINE_SPIN_EN enables hit-zone dy
module ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int SCREEN_H      = DEF_SCREEN_H,
    parameter int BALL_W        = 20,
    parameter int BALL_H        = 20,
    parameter int P1_X          = 10,
    parameter int P2_X          = 615,
    parameter int PADDLE_W      = 15,
    parameter int PADDLE_H      = 100,
    parameter int START_SPEED   = 5,
    parameter int MAX_SPEED     = 15,
    parameter int SPEED_STEP    = 5,
    parameter int HITS_PER_STEP = 5,
    parameter int SERVE_DELAY   = 60,
    parameter logic [7:0] START_KEY   = KEY_START,
    parameter logic [7:0] RESTART_KEY = KEY_RESTART
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_frame_tick,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_byte,
    input  logic [9:0] i_p1_y,
    input  logic [9:0] i_p2_y,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic       o_p1_scored,
    output logic       o_p2_scored,
    output logic [1:0] o_state,
    output logic [4:0] o_speed
);

    localparam logic [9:0] CX = 10'((SCREEN_W - BALL_W) / 2);
    localparam logic [9:0] CY = 10'((SCREEN_H - BALL_H) / 2);
    localparam logic signed [10:0] P1_FACE = 11'(P1_X + PADDLE_W);
    localparam logic signed [10:0] P2_FACE = 11'(P2_X - BALL_W);
    localparam logic signed [10:0] X_LIM   = 11'(SCREEN_W - BALL_W);
    localparam logic signed [10:0] Y_LIM   = 11'(SCREEN_H - BALL_H);
    localparam logic [9:0] P1_FACE_X = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] P2_FACE_X = 10'(P2_X - BALL_W);
    localparam logic [9:0] Y_LIM_Y   = 10'(SCREEN_H - BALL_H);
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    state_t            state, state_n;
    logic [9:0]        ball_x, ball_y, x_n, y_n;
    logic              dx_right, dy_down, dy_half, serve_right, serve_down, scorer_p1;
    logic              dxr_n, dyd_n, dyh_n, srv_r_n, srv_d_n, scp1_n;
    logic [CNT_W-1:0]  serve_cnt, cnt_n;
    logic [4:0]        speed, dy_step;
    logic signed [10:0] cur_x, cur_y, spd, dys, next_x, next_y;
    logic              ov1, ov2, hit_p1, hit_p2, hit, restart, clear;

`ifdef BALL_ENGINE_SPIN_EN
    function automatic logic mid_third(input logic [9:0] by, input logic [9:0] py);
        logic [10:0] cy, lo, hi;
        cy = 11'(by) + 11'(BALL_H / 2);
        lo = 11'(py) + 11'(PADDLE_H / 3);
        hi = 11'(py) + 11'(2 * PADDLE_H / 3);
        return (cy >= lo) && (cy < hi);
    endfunction
`endif

    // dy_half stays 0 unless spin is built in, leaving pure 45-degree motion.
    assign dy_step = dy_half ? ((speed > 5'd1) ? (speed >> 1) : 5'd1) : speed;
    assign cur_x   = {1'b0, ball_x};
    assign cur_y   = {1'b0, ball_y};
    assign spd     = {6'd0, speed};
    assign dys     = {6'd0, dy_step};
    assign next_x  = dx_right ? cur_x + spd : cur_x - spd;
    assign next_y  = dy_down  ? cur_y + dys : cur_y - dys;

    assign ov1 = (11'(ball_y) + 11'(BALL_H) > 11'(i_p1_y)) && (11'(ball_y) < 11'(i_p1_y) + 11'(PADDLE_H));
    assign ov2 = (11'(ball_y) + 11'(BALL_H) > 11'(i_p2_y)) && (11'(ball_y) < 11'(i_p2_y) + 11'(PADDLE_H));
    assign hit_p1 = !dx_right && (cur_x >= P1_FACE) && (next_x < P1_FACE) && ov1;
    assign hit_p2 =  dx_right && (cur_x <= P2_FACE) && (next_x > P2_FACE) && ov2;

    assign restart = i_key_valid && (i_key_byte == RESTART_KEY);
    assign clear   = restart || (state == SCORED);

    always_comb begin
        state_n = state;
        x_n     = ball_x;
        y_n     = ball_y;
        dxr_n   = dx_right;
        dyd_n   = dy_down;
        dyh_n   = dy_half;
        srv_r_n = serve_right;
        srv_d_n = serve_down;
        scp1_n  = scorer_p1;
        cnt_n   = serve_cnt;
        hit     = 1'b0;
        case (state)
            IDLE: begin
                x_n = CX;
                y_n = CY;
                if (i_key_valid && i_key_byte == START_KEY) begin
                    state_n = SERVE;
                    cnt_n   = '0;
                end
            end
            SERVE: begin
                x_n = CX;
                y_n = CY;
                if (i_frame_tick) begin
                    if (serve_cnt == CNT_W'(SERVE_DELAY - 1)) begin
                        state_n = PLAY;
                        cnt_n   = '0;
                        dxr_n   = serve_right;
                        dyd_n   = serve_down;
                        srv_d_n = !serve_down;
                        dyh_n   = 1'b0;
                    end else begin
                        cnt_n = serve_cnt + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                if (i_frame_tick) begin
                    if (hit_p1 || hit_p2) begin
                        hit   = 1'b1;
                        x_n   = hit_p1 ? P1_FACE_X : P2_FACE_X;
                        dxr_n = hit_p1;
`ifdef BALL_ENGINE_SPIN_EN
                        dyh_n = hit_p1 ? mid_third(ball_y, i_p1_y) : mid_third(ball_y, i_p2_y);
`endif
                    end else if (next_x < 0) begin
                        state_n = SCORED;
                        scp1_n  = 1'b0;
                    end else if (next_x > X_LIM) begin
                        state_n = SCORED;
                        scp1_n  = 1'b1;
                    end else begin
                        x_n = next_x[9:0];
                    end
                    if (next_y <= 0) begin
                        y_n   = '0;
                        dyd_n = 1'b1;
                    end else if (next_y >= Y_LIM) begin
                        y_n   = Y_LIM_Y;
                        dyd_n = 1'b0;
                    end else begin
                        y_n = next_y[9:0];
                    end
                end
            end
            SCORED: begin
                // Next serve heads toward whoever conceded.
                state_n = SERVE;
                x_n     = CX;
                y_n     = CY;
                cnt_n   = '0;
                srv_r_n = scorer_p1;
            end
            default: state_n = IDLE;
        endcase
        if (restart) begin
            state_n = IDLE;
            x_n     = CX;
            y_n     = CY;
            cnt_n   = '0;
            srv_r_n = 1'b1;
            srv_d_n = 1'b1;
            dyh_n   = 1'b0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state       <= IDLE;
            ball_x      <= CX;
            ball_y      <= CY;
            dx_right    <= 1'b1;
            dy_down     <= 1'b1;
            dy_half     <= 1'b0;
            serve_right <= 1'b1;
            serve_down  <= 1'b1;
            scorer_p1   <= 1'b0;
            serve_cnt   <= '0;
        end else begin
            state       <= state_n;
            ball_x      <= x_n;
            ball_y      <= y_n;
            dx_right    <= dxr_n;
            dy_down     <= dyd_n;
            dy_half     <= dyh_n;
            serve_right <= srv_r_n;
            serve_down  <= srv_d_n;
            scorer_p1   <= scp1_n;
            serve_cnt   <= cnt_n;
        end
    end

    ball_speed_ctrl #(
        .START_SPEED  (START_SPEED),
        .MAX_SPEED    (MAX_SPEED),
        .SPEED_STEP   (SPEED_STEP),
        .HITS_PER_STEP(HITS_PER_STEP)
    ) u_speed (
        .clk   (i_CLK),
        .resetn(i_RST_N),
        .hit   (hit),
        .clear (clear),
        .speed (speed)
    );

    assign o_ball_x    = ball_x;
    assign o_ball_y    = ball_y;
    assign o_state     = state;
    assign o_speed     = speed;
    assign o_p1_scored = (state == SCORED) &&  scorer_p1;
    assign o_p2_scored = (state == SCORED) && !scorer_p1;

endmodule
